// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the MEM-stage data memory.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Load context captured at acceptance and applied when the RAM word comes back.
    typedef struct packed {
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
    } ld_ctx_t;

    // Big-endian lanes: byte enable bit 3 is word bits [31:24] (offset 0).
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b1000 >> off;
            SIZE_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response port of the data memory; master is the datapath, slave the memory.
interface data_memory_if #(
    parameter int unsigned ADDR_WIDTH = 18
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_ram.sv
// Single-port synchronous word RAM with byte write enables and a registered read port.
module data_mem_ram #(
    parameter int unsigned DEPTH_WORDS = 65536,
    parameter int unsigned AW          = 16,
    parameter string       INIT_FILE   = ""
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read data only updates on a read, so it holds through any latency wait.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: valid/ready request, single outstanding response,
// byte/half/word access with sign or zero extension and error reporting.
module data_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned DEPTH_WORDS  = 65536,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = ""
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ld_ctx_t          ctx_q, ctx_d;
    logic             rsp_valid_q;
    logic             rsp_error_q;
    logic             rsp_load_q;

    logic             req_ready_c;
    logic             accept_c;
    logic             err_c;
    logic [IDX_W-1:0] idx_c;
    logic [1:0]       off_c;
    logic             ram_en_c;
    logic [3:0]       ram_we_c;
    logic [31:0]      ram_wdata_c;
    logic [31:0]      ram_rdata;

    assign idx_c       = bus.req_addr[ADDR_WIDTH-1:2];
    assign off_c       = bus.req_addr[1:0];
    assign req_ready_c = !rst && (state_q != WAIT);
    assign accept_c    = bus.req_valid && req_ready_c;

    // Request legality, evaluated on the accepted request only.
    always_comb begin
        err_c = 1'b0;
        if (bus.req_size == SIZE_ILL)                      err_c = 1'b1;
        if (bus.req_size == SIZE_HALF && off_c[0])         err_c = 1'b1;
        if (bus.req_size == SIZE_WORD && off_c != 2'b00)   err_c = 1'b1;
        if (32'(idx_c) >= DEPTH_WORDS)                     err_c = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables pick the right copy.
    always_comb begin
        ram_wdata_c = bus.req_wdata;
        case (bus.req_size)
            SIZE_BYTE: ram_wdata_c = {4{bus.req_wdata[7:0]}};
            SIZE_HALF: ram_wdata_c = {2{bus.req_wdata[15:0]}};
            default:   ram_wdata_c = bus.req_wdata;
        endcase
    end

    assign ram_en_c = accept_c && !err_c;
    assign ram_we_c = (ram_en_c && bus.req_write) ? byte_en(bus.req_size, off_c) : 4'b0000;

    data_mem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (RAM_AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (RAM_AW'(idx_c)),
        .wdata_i (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    // Next-state, latency counter and load context capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept_c) begin
                    ctx_d.size = bus.req_size;
                    ctx_d.off  = off_c;
                    ctx_d.uns  = bus.req_unsigned;
                    if (bus.req_write || err_c || READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ctx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctx_q       <= ctx_d;
            rsp_valid_q <= (state_d == RESP);
            rsp_error_q <= accept_c && err_c;
            if (accept_c) begin
                rsp_load_q <= !bus.req_write && !err_c;
            end
        end
    end

    function automatic logic [31:0] load_align(input logic [31:0] w, input ld_ctx_t c);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {~c.off, 3'b000});
        h = c.off[1] ? w[15:0] : w[31:16];
        case (c.size)
            SIZE_BYTE: r = c.uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = c.uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   r = w;
        endcase
        return r;
    endfunction

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = (rsp_valid_q && rsp_load_q) ? load_align(ram_rdata, ctx_q) : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench: one instance at read latency 1, one at latency 3, both 1024 words deep.
module tb_data_memory;

    localparam int unsigned AW = 18;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    typedef struct packed {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic          rv [2];
    logic          rw [2];
    logic [1:0]    rs [2];
    logic          ru [2];
    logic [AW-1:0] ra [2];
    logic [31:0]   rd [2];
    logic          rdy   [2];
    logic          rsp_v [2];
    logic [31:0]   rdat  [2];
    logic          rerr  [2];

    exp_t sb [2][$];
    exp_t mon_e;

    data_memory_if #(.ADDR_WIDTH(AW)) bus1 ();
    data_memory_if #(.ADDR_WIDTH(AW)) bus3 ();

    assign bus1.req_valid = rv[0];  assign bus3.req_valid = rv[1];
    assign bus1.req_write = rw[0];  assign bus3.req_write = rw[1];
    assign bus1.req_size  = rs[0];  assign bus3.req_size  = rs[1];
    assign bus1.req_unsigned = ru[0];  assign bus3.req_unsigned = ru[1];
    assign bus1.req_addr  = ra[0];  assign bus3.req_addr  = ra[1];
    assign bus1.req_wdata = rd[0];  assign bus3.req_wdata = rd[1];
    assign rdy[0]   = bus1.req_ready;  assign rdy[1]   = bus3.req_ready;
    assign rsp_v[0] = bus1.rsp_valid;  assign rsp_v[1] = bus3.rsp_valid;
    assign rdat[0]  = bus1.rsp_rdata;  assign rdat[1]  = bus3.rsp_rdata;
    assign rerr[0]  = bus1.rsp_error;  assign rerr[1]  = bus3.rsp_error;

    data_memory #(.ADDR_WIDTH(AW), .DEPTH_WORDS(1024), .READ_LATENCY(1), .INIT_FILE("")) dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    data_memory #(.ADDR_WIDTH(AW), .DEPTH_WORDS(1024), .READ_LATENCY(3), .INIT_FILE("")) dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Responses are popped and checked against value, error flag and arrival cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_v[d]) begin
                if (sb[d].size() == 0) begin
                    check_eq(d == 0 ? "unexpected_rsp_lat1" : "unexpected_rsp_lat3", 32'd1, 32'd0);
                end else begin
                    mon_e = sb[d].pop_front();
                    check_eq("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                    check_eq("rsp_rdata", rdat[d], mon_e.data);
                    check_eq("rsp_error", 32'(rerr[d]), 32'(mon_e.err));
                end
            end else if (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
                mon_e = sb[d].pop_front();
                check_eq("rsp_missing", 32'(cyc), 32'(mon_e.due) + 32'd1000);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on instance d; returns the cycle count seen just before the accepting edge.
    task automatic send(input int d, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input bit exp_rsp,
                        output int acc);
        exp_t e;
        bit   ok;
        int   lat;
        ok = 1'b0;
        acc = -1;
        rw[d] = wr; rs[d] = sz; ru[d] = un; ra[d] = a; rd[d] = wd; rv[d] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy[d]) ok = 1'b1;
        end
        if (!ok) begin
            check_eq("req_accept_timeout", 32'd0, 32'd1);
            rv[d] = 1'b0;
        end else begin
            acc = cyc;
            lat = (d == 1 && !wr && !ee) ? 3 : 1;
            e.due = cyc + lat;
            e.data = ed;
            e.err = ee;
            if (exp_rsp) sb[d].push_back(e);
            step();
            rv[d] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(sb[0].size() + sb[1].size()), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; rs[d] = SZ_W; ru[d] = 1'b0; ra[d] = '0; rd[d] = '0;
        end
        rst1 = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        check_eq("ready_during_rst", 32'(rdy[0]), 32'd0);
        check_eq("ready_during_rst3", 32'(rdy[1]), 32'd0);
        step();
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check_eq("reset_ready", 32'(rdy[0]), 32'd1);
        check_eq("reset_rsp_valid", 32'(rsp_v[0]), 32'd0);
        check_eq("reset_rdata", rdat[0], 32'h0);
        check_eq("reset_error", 32'(rerr[0]), 32'd0);
        check_eq("reset_ready3", 32'(rdy[1]), 32'd1);
        step();

        // Word store/load, byte merge, extension (latency 1).
        send(0, 1'b1, SZ_W, 1'b0, 18'h00010, 32'h12345678, 32'h0, 1'b0, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h00010, 32'h0, 32'h12345678, 1'b0, 1, acc);
        send(0, 1'b1, SZ_W, 1'b0, 18'h00020, 32'h00000000, 32'h0, 1'b0, 1, acc);
        send(0, 1'b1, SZ_B, 1'b0, 18'h00021, 32'hFFFFFFAB, 32'h0, 1'b0, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h00020, 32'h0, 32'h00AB0000, 1'b0, 1, acc);
        send(0, 1'b1, SZ_W, 1'b0, 18'h00030, 32'h80FF7F01, 32'h0, 1'b0, 1, acc);
        send(0, 1'b0, SZ_B, 1'b0, 18'h00030, 32'h0, 32'hFFFFFF80, 1'b0, 1, acc);
        send(0, 1'b0, SZ_H, 1'b1, 18'h00032, 32'h0, 32'h00007F01, 1'b0, 1, acc);
        send(0, 1'b0, SZ_H, 1'b0, 18'h00030, 32'h0, 32'hFFFF80FF, 1'b0, 1, acc);
        send(0, 1'b0, SZ_B, 1'b0, 18'h00031, 32'h0, 32'hFFFFFFFF, 1'b0, 1, acc);
        send(0, 1'b0, SZ_B, 1'b1, 18'h00033, 32'h0, 32'h00000001, 1'b0, 1, acc);

        // Error cases, including a misaligned store that must not write.
        send(0, 1'b0, SZ_H, 1'b0, 18'h00031, 32'h0, 32'h0, 1'b1, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h00022, 32'h0, 32'h0, 1'b1, 1, acc);
        send(0, 1'b0, SZ_X, 1'b0, 18'h00020, 32'h0, 32'h0, 1'b1, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h01000, 32'h0, 32'h0, 1'b1, 1, acc);
        send(0, 1'b1, SZ_W, 1'b0, 18'h00022, 32'hDEADBEEF, 32'h0, 1'b1, 1, acc);
        send(0, 1'b1, SZ_B, 1'b0, 18'h01001, 32'h000000EE, 32'h0, 1'b1, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h00020, 32'h0, 32'h00AB0000, 1'b0, 1, acc);
        send(0, 1'b1, SZ_W, 1'b0, 18'h00FFC, 32'hCAFEF00D, 32'h0, 1'b0, 1, acc);
        send(0, 1'b0, SZ_W, 1'b0, 18'h00FFC, 32'h0, 32'hCAFEF00D, 1'b0, 1, acc);
        drain();

        // Latency 3: ready low for two cycles, response on the third.
        send(1, 1'b1, SZ_W, 1'b0, 18'h00010, 32'h12345678, 32'h0, 1'b0, 1, acc);
        send(1, 1'b0, SZ_W, 1'b0, 18'h00010, 32'h0, 32'h12345678, 1'b0, 1, acc);
        @(negedge clk); check_eq("lat3_ready_c1", 32'(rdy[1]), 32'd0);
        @(negedge clk); check_eq("lat3_ready_c2", 32'(rdy[1]), 32'd0);
        @(negedge clk); check_eq("lat3_ready_c3", 32'(rdy[1]), 32'd1);
        step();

        prev = -1;
        for (int i = 0; i < 8; i++) begin
            send(1, 1'b1, SZ_W, 1'b0, AW'(32'h40 + 32'(4 * i)), 32'h11111111 * 32'(i + 1),
                 32'h0, 1'b0, 1, acc);
            if (i > 0) check_eq("b2b_store_accept", 32'(acc), 32'(prev + 1));
            prev = acc;
        end
        send(1, 1'b0, SZ_W, 1'b0, 18'h00054, 32'h0, 32'h66666666, 1'b0, 1, acc);
        send(1, 1'b0, SZ_H, 1'b1, 18'h0004E, 32'h0, 32'h00004444, 1'b0, 1, acc);
        drain();

        // Reset one cycle after a load is accepted: no response may follow.
        send(1, 1'b0, SZ_W, 1'b0, 18'h00010, 32'h0, 32'h0, 1'b0, 0, acc);
        rst3 = 1'b1;
        @(negedge clk); check_eq("ready_in_midread_rst", 32'(rdy[1]), 32'd0);
        step();
        rst3 = 1'b0;
        @(negedge clk);
        check_eq("ready_after_midread_rst", 32'(rdy[1]), 32'd1);
        check_eq("rsp_after_midread_rst", 32'(rsp_v[1]), 32'd0);
        repeat (4) @(negedge clk);
        step();

        // A store presented during reset is dropped.
        rst3 = 1'b1;
        rv[1] = 1'b1; rw[1] = 1'b1; rs[1] = SZ_W; ra[1] = 18'h00010; rd[1] = 32'h0BADF00D;
        step();
        rv[1] = 1'b0;
        rst3 = 1'b0;
        step();
        send(1, 1'b0, SZ_W, 1'b0, 18'h00010, 32'h0, 32'h12345678, 1'b0, 1, acc);
        drain();

        check_eq("sb_empty_lat1", 32'(sb[0].size()), 32'd0);
        check_eq("sb_empty_lat3", 32'(sb[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
